// File: rtl/square_pkg.sv
// square_pkg: fixed widths and FSM state type shared by square
package square_pkg;
  localparam int Y_W = 4;
  localparam int X_W = 8;
  localparam int CNT_W = 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/square.sv
// square: squares y_in (clk, rst, y_in, y_ready -> x_out, x_ready) by shift-and-add, one bit per cycle; SQUARE_SKID_EN adds a one-entry skid buffer
module square
  import square_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [Y_W-1:0] y_in,
  input  logic           y_ready,
  output logic [X_W-1:0] x_out,
  output logic           x_ready
);
  state_t state, state_n;
  logic [Y_W-1:0] op, mul, src;
  logic [X_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt;
  logic start, last;
`ifdef SQUARE_SKID_EN
  logic [Y_W-1:0] skid_val;
  logic skid_vld;
`endif
  always_comb begin
    sum = acc + (mul[cnt] ? X_W'(op) << cnt : '0);
    last = (state == CALC) && (&cnt);
`ifdef SQUARE_SKID_EN
    start = ((state == IDLE) && y_ready) || ((state == DONE) && (skid_vld || y_ready));
    src = ((state == DONE) && skid_vld) ? skid_val : y_in;
`else
    start = (state != CALC) && y_ready;
    src = y_in;
`endif
    state_n = start ? CALC : last ? DONE : (state == CALC) ? CALC : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      mul <= '0;
      acc <= '0;
      cnt <= '0;
      x_out <= '0;
      x_ready <= 1'b0;
    end else begin
      state <= state_n;
      x_ready <= last;
      if (start) begin
        op <= src;
        mul <= src;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (last) x_out <= sum;
    end
  end
`ifdef SQUARE_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld <= 1'b0;
      skid_val <= '0;
    end else if ((state == CALC) && y_ready && !skid_vld) begin
      skid_val <= y_in;
      skid_vld <= 1'b1;
    end else if ((state == DONE) && skid_vld) begin
      skid_val <= y_ready ? y_in : skid_val;
      skid_vld <= y_ready;
    end
  end
`endif
endmodule

// File: tb/tb_square.sv
// tb_square: randomized and directed checks of square against a transaction-level model
module tb_square;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] y_in = '0;
  logic y_ready = 1'b0;
  logic [7:0] x_out;
  logic x_ready;
  int n_chk = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc_no = 0;
  int m_left = 0;
  logic [7:0] m_res = '0;
  logic [7:0] exp_xo = '0;
  logic exp_xr = 1'b0;
  bit sk_v = 1'b0;
  logic [3:0] sk_d = '0;

  square dut (.clk(clk), .rst(rst), .y_in(y_in), .y_ready(y_ready), .x_out(x_out), .x_ready(x_ready));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (x_ready !== exp_xr || x_out !== exp_xo) begin
        n_bad++;
        $display("FAIL cycle %0d: x_ready=%0b x_out=%0d, required x_ready=%0b x_out=%0d", cyc_no, x_ready, x_out, exp_xr, exp_xo);
      end
    end
  end

  task automatic model(input bit r, input bit yr, input logic [3:0] y);
    bit was_done, go;
    logic [3:0] a;
    was_done = exp_xr;
    go = 1'b0;
    a = '0;
    if (r) begin
      m_left = 0;
      exp_xo = '0;
      exp_xr = 1'b0;
      sk_v = 1'b0;
    end else if (m_left > 0) begin
`ifdef SQUARE_SKID_EN
      if (yr && !sk_v) begin
        sk_v = 1'b1;
        sk_d = y;
      end
`endif
      m_left--;
      exp_xr = (m_left == 0);
      if (m_left == 0) exp_xo = m_res;
    end else begin
      exp_xr = 1'b0;
`ifdef SQUARE_SKID_EN
      if (was_done && sk_v) begin
        go = 1'b1;
        a = sk_d;
        if (yr) sk_d = y;
        else sk_v = 1'b0;
      end else
`endif
      if (yr) begin
        go = 1'b1;
        a = y;
      end
      if (go) begin
        m_res = 8'(a) * 8'(a);
        m_left = 4;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit yr, input logic [3:0] y);
    rst = r;
    y_ready = yr;
    y_in = y;
    @(posedge clk);
    model(r, yr, y);
    cyc_no++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_lit(input string nm, input logic [7:0] want_xo, input bit want_xr);
    n_chk++;
    if (x_out !== want_xo || x_ready !== want_xr || exp_xo !== want_xo || exp_xr !== want_xr) begin
      n_bad++;
      $display("FAIL %s: dut x_out=%0d x_ready=%0b model x_out=%0d x_ready=%0b, required x_out=%0d x_ready=%0b", nm, x_out, x_ready, exp_xo, exp_xr, want_xo, want_xr);
    end
  endtask

  initial begin
    cyc(1'b1, 1'b1, 4'd9);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 4'd0);
    check_lit("reset", 8'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd14);
    idle(3);
    check_lit("sq14_early", 8'd0, 1'b0);
    idle(1);
    check_lit("sq14", 8'hC4, 1'b1);
    idle(1);
    check_lit("sq14_pulse_end", 8'hC4, 1'b0);
    cyc(1'b0, 1'b1, 4'd15);
    idle(4);
    check_lit("sq15", 8'hE1, 1'b1);
    idle(3);
    check_lit("sq15_hold", 8'hE1, 1'b0);
    cyc(1'b0, 1'b1, 4'd0);
    idle(3);
    check_lit("sq0_calc_hold", 8'hE1, 1'b0);
    idle(1);
    check_lit("sq0", 8'h00, 1'b1);
    idle(2);
    cyc(1'b0, 1'b1, 4'd5);
    idle(4);
    check_lit("b2b_25", 8'd25, 1'b1);
    cyc(1'b0, 1'b1, 4'd7);
    idle(3);
    check_lit("b2b_gap", 8'd25, 1'b0);
    idle(1);
    check_lit("b2b_49", 8'd49, 1'b1);
    idle(2);
    cyc(1'b0, 1'b1, 4'd9);
    idle(1);
    cyc(1'b1, 1'b0, 4'd0);
    idle(5);
    check_lit("abandon", 8'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd3);
    idle(4);
    check_lit("after_abandon", 8'd9, 1'b1);
    idle(2);
    cyc(1'b0, 1'b1, 4'd5);
    cyc(1'b0, 1'b1, 4'd6);
    cyc(1'b0, 1'b1, 4'd2);
    idle(2);
    check_lit("calc_strobe_25", 8'd25, 1'b1);
    idle(5);
`ifdef SQUARE_SKID_EN
    check_lit("skid_36", 8'd36, 1'b1);
`else
    check_lit("ignored_strobe", 8'd25, 1'b0);
`endif
    idle(6);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 4'(i));
      idle(4);
      check_lit("sweep", 8'(i * i), 1'b1);
    end
    idle(2);
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    idle(12);
    chk_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 The module SHALL have no parameters; widths are fixed constants from square_pkg (Y_W=4, X_W=8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 y_in  input  4  unsigned operand, sampled only on the accept edge.
REQ-005 y_ready  input  1  single-cycle strobe marking y_in valid.
REQ-006 x_out  output  8  unsigned result y_in*y_in; registered.
REQ-007 x_ready  output  1  single-cycle strobe marking x_out valid; registered.

Function
REQ-008 The module SHALL compute x_out = y_in squared, exact, by iterative shift-and-add, one multiplier bit per cycle.
REQ-009 FSM states SHALL be IDLE, CALC and DONE.
REQ-010 IDLE: y_ready=1 at an edge SHALL latch y_in into operand and multiplier registers, clear the accumulator and bit counter, and go to CALC.
REQ-011 CALC: each edge SHALL add (operand << cnt) to the 8-bit accumulator when multiplier bit cnt is 1, then increment cnt; after the 4th CALC edge (cnt=3) the FSM SHALL go to DONE.
REQ-012 At that 4th CALC edge, x_out SHALL load the final sum and x_ready SHALL go to 1.
REQ-013 Latency: x_ready SHALL be high in the cycle beginning 4 edges after the accept edge.
REQ-014 x_ready SHALL be high for exactly one cycle (DONE); DONE SHALL always leave at the next edge.
REQ-015 DONE: y_ready=1 SHALL be accepted as in IDLE (next state CALC); otherwise next state SHALL be IDLE. Max throughput is one result per 5 cycles.
REQ-016 x_out SHALL hold the last result until the next result loads; it SHALL not change during CALC.
REQ-017 The accumulator SHALL never overflow (max 15*15=225 < 256); no saturation logic.
REQ-018 Without SQUARE_SKID_EN, y_ready during CALC SHALL be ignored, with no state change.

Reset
REQ-019 rst=1 at an edge SHALL force state IDLE, x_out=0, x_ready=0, cnt=0, accumulator=0, skid buffer empty; rst SHALL take priority over y_ready.
REQ-020 Reset during CALC SHALL abandon the operation; no x_ready SHALL be produced for it.
REQ-021 The first accept after reset SHALL be possible at the first edge with rst=0.

Configuration
REQ-022 Macro SQUARE_SKID_EN SHALL, when defined, add a one-entry skid buffer (value plus valid flag).
REQ-023 With SQUARE_SKID_EN defined, y_ready during CALC SHALL store y_in in the buffer if empty; if the buffer is full, the new strobe SHALL be dropped and the stored value kept.
REQ-024 With SQUARE_SKID_EN defined, in DONE with the buffer full, the FSM SHALL start the buffered operand (go to CALC). A simultaneous y_ready SHALL be written into the buffer, which stays full.
REQ-025 With SQUARE_SKID_EN defined, in DONE with the buffer empty, behaviour SHALL follow REQ-015.
REQ-026 Without SQUARE_SKID_EN, no buffer logic SHALL be synthesised.

Structure
REQ-027 square_pkg SHALL hold Y_W, X_W, the state enum type (IDLE, CALC, DONE) and CNT_W=2.
REQ-028 The design SHALL be a single module; no sub-module is warranted.

Verification
REQ-029 Reset, then y_in=14 with y_ready for 1 cycle -> x_ready pulses once 4 edges later with x_out=0xC4 (196).
REQ-030 y_in=15 -> x_out=0xE1; then y_in=0 -> x_out=0x00. Between results, x_out holds 0xE1.
REQ-031 Back-to-back: y_in=5 accepted, y_in=7 strobed in the DONE cycle -> x_out=25, then x_out=49, with x_ready pulses 5 cycles apart.
REQ-032 rst asserted on the 2nd CALC cycle of y_in=9 -> no x_ready; x_out=0. A following y_in=3 -> x_out=9.
REQ-033 Without SQUARE_SKID_EN, y_in=6 strobed during CALC of y_in=5 -> only x_out=25 appears. With SQUARE_SKID_EN, y_in=6 then y_in=2 strobed during that CALC -> x_out=25 then x_out=36; the y_in=2 strobe is dropped.
REQ-034 Exhaustive sweep of y_in 0..15 -> each x_out equals y_in squared, with exactly one x_ready per accepted operand.
